pipeline_stall_ctrl: RTL and testbench

- Central sequencer for the five-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC.
- Generates per-register load enables and bubble/flush strobes from three inputs: I-cache and D-cache response handshakes, the load-use hazard, and taken-branch redirects.
- Tracks I-cache and D-cache misses that are outstanding at the same time, and captures an early I-cache response so the fetch is not lost while the D-cache is still stalling.

---
 rtl/pipeline_stall_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush sequencer: load enables, bubbles and fetch-word capture across cache misses.
// Optional `STALL_PERF_CNT_EN` adds saturating stall/hazard performance counters.
module pipeline_stall_ctrl #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic [width-1:0] imem_rdata,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             ex_br_taken,
    input  logic             load_use_hazard,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [width-1:0] fetch_word,
    output logic             stall
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]      i_stall_cnt,
    output logic [31:0]      d_stall_cnt,
    output logic [31:0]      hazard_cnt
`endif
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] WAIT_I  = 2'd1;
    localparam logic [1:0] WAIT_D  = 2'd2;
    localparam logic [1:0] WAIT_ID = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             i_held_q, i_held_d;
    logic [width-1:0] i_hold_data_q, i_hold_data_d;

    logic i_wait, d_wait, adv;

    assign i_wait = imem_req & ~imem_resp & ~i_held_q;
    assign d_wait = dmem_req & ~dmem_resp;
    assign adv    = ~i_wait & ~d_wait;

    assign fetch_word = i_held_q ? i_hold_data_q : imem_rdata;

    always_comb begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        stall       = 1'b0;
        if (rst) begin
            if (d_wait) begin
                stall = 1'b1;
            end else if (i_wait || (load_use_hazard && !ex_br_taken)) begin
                // Front end holds; a bubble enters ID_EX while the back end drains.
                load_id_ex  = 1'b1;
                flush_id_ex = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                stall       = 1'b1;
            end else begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                flush_if_id = ex_br_taken;
                flush_id_ex = ex_br_taken;
            end
        end
    end

    always_comb begin
        i_held_d      = i_held_q;
        i_hold_data_d = i_hold_data_q;
        if (imem_resp && d_wait && !i_held_q) begin
            i_held_d      = 1'b1;
            i_hold_data_d = imem_rdata;
        end else if (adv && i_held_q && (ex_br_taken || !load_use_hazard)) begin
            // Consumed by IF_ID, or discarded by a redirect; a load-use bubble keeps it.
            i_held_d = 1'b0;
        end
    end

    always_comb begin
        case ({i_wait, d_wait})
            2'b11:   state_d = WAIT_ID;
            2'b10:   state_d = WAIT_I;
            2'b01:   state_d = WAIT_D;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            i_held_q      <= 1'b0;
            i_hold_data_q <= '0;
        end else begin
            state_q       <= state_d;
            i_held_q      <= i_held_d;
            i_hold_data_q <= i_hold_data_d;
        end
    end

    // An outstanding I-miss can never coexist with a captured fetch word.
    no_hold_during_i_miss: assert property (@(posedge clk) disable iff (!rst)
        (state_q == WAIT_I || state_q == WAIT_ID) |-> !i_held_q);

`ifdef STALL_PERF_CNT_EN
    logic [31:0] i_stall_cnt_q, d_stall_cnt_q, hazard_cnt_q;
    logic        hazard_bubble;

    assign hazard_bubble = adv & load_use_hazard & ~ex_br_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_stall_cnt_q <= '0;
            d_stall_cnt_q <= '0;
            hazard_cnt_q  <= '0;
        end else begin
            if (i_wait && !d_wait && i_stall_cnt_q != '1) i_stall_cnt_q <= i_stall_cnt_q + 32'd1;
            if (d_wait && d_stall_cnt_q != '1)            d_stall_cnt_q <= d_stall_cnt_q + 32'd1;
            if (hazard_bubble && hazard_cnt_q != '1)      hazard_cnt_q  <= hazard_cnt_q + 32'd1;
        end
    end

    assign i_stall_cnt = i_stall_cnt_q;
    assign d_stall_cnt = d_stall_cnt_q;
    assign hazard_cnt  = hazard_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed per-cycle vectors, expectations queued, monitor compares.
module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_resp, dmem_req, dmem_resp, ex_br_taken, load_use_hazard;
    logic [31:0] imem_rdata;
    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex, stall;
    logic [31:0] fetch_word;

    pipeline_stall_ctrl #(.width(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_resp       (imem_resp),
        .imem_rdata      (imem_rdata),
        .dmem_req        (dmem_req),
        .dmem_resp       (dmem_resp),
        .ex_br_taken     (ex_br_taken),
        .load_use_hazard (load_use_hazard),
        .load_pc         (load_pc),
        .load_if_id      (load_if_id),
        .load_id_ex      (load_id_ex),
        .load_ex_mem     (load_ex_mem),
        .load_mem_wb     (load_mem_wb),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .fetch_word      (fetch_word),
        .stall           (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  ld;     // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic [1:0]  fl;     // {if_id, id_ex}
        logic        st;
        bit          chk_fw;
        logic [31:0] fw;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [4:0] ALL  = 5'b11111;
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] BUB  = 5'b00111;

    // Drive one cycle of inputs, queue what the outputs must be during that cycle.
    task automatic step(input string nm, input logic r, input logic ireq, input logic iresp,
                        input logic [31:0] rdata, input logic dreq, input logic dresp,
                        input logic br, input logic luh, input logic [4:0] ld,
                        input logic [1:0] fl, input logic st, input bit chk, input logic [31:0] fw);
        exp_t e;
        rst = r; imem_req = ireq; imem_resp = iresp; imem_rdata = rdata;
        dmem_req = dreq; dmem_resp = dresp; ex_br_taken = br; load_use_hazard = luh;
        e.name = nm; e.ld = ld; e.fl = fl; e.st = st; e.chk_fw = chk; e.fw = fw;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [4:0] ald;
            logic [1:0] afl;
            e   = q.pop_front();
            ald = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
            afl = {flush_if_id, flush_id_ex};
            n_cmp++;
            if (ald !== e.ld || afl !== e.fl || stall !== e.st) begin
                n_err++;
                $display("FAIL %s ctrl: got ld=%b fl=%b stall=%b, want ld=%b fl=%b stall=%b",
                         e.name, ald, afl, stall, e.ld, e.fl, e.st);
            end
            if (e.chk_fw) begin
                n_cmp++;
                if (fetch_word !== e.fw) begin
                    n_err++;
                    $display("FAIL %s fetch_word: got %h, want %h", e.name, fetch_word, e.fw);
                end
            end
        end
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        rst = 1'b0; imem_req = 1'b0; imem_resp = 1'b0; imem_rdata = '0;
        dmem_req = 1'b0; dmem_resp = 1'b0; ex_br_taken = 1'b0; load_use_hazard = 1'b0;
        @(posedge clk);
        #1;
        //    name          rst ireq iresp rdata         dreq dresp br luh  ld    fl     st  chk fw
        step("reset",       0,  1,   1,    32'h12345678, 0,   0,    0, 0,   NONE, 2'b00, 0,  0,  '0);
        step("first_fetch", 1,  1,   1,    32'h11111111, 0,   0,    0, 0,   ALL,  2'b00, 0,  1,  32'h11111111);
        step("no_ireq",     1,  0,   0,    32'h0,        0,   0,    0, 0,   ALL,  2'b00, 0,  0,  '0);
        for (int i = 0; i < 3; i++)
            step("imiss",   1,  1,   0,    32'hDEADBEEF, 0,   0,    0, 0,   BUB,  2'b01, 1,  0,  '0);
        step("imiss_done",  1,  1,   1,    32'h00A00093, 0,   0,    0, 0,   ALL,  2'b00, 0,  1,  32'h00A00093);
        // D-miss with I-response captured in its first cycle
        step("dmiss_cap",   1,  1,   1,    32'h00100113, 1,   0,    0, 0,   NONE, 2'b00, 1,  1,  32'h00100113);
        for (int i = 0; i < 3; i++)
            step("dmiss_held", 1, 1,   0,    32'hBAD0BAD0, 1,   0,    0, 0,   NONE, 2'b00, 1,  1,  32'h00100113);
        step("dmiss_done",  1,  1,   0,    32'hBAD0BAD0, 1,   1,    0, 0,   ALL,  2'b00, 0,  1,  32'h00100113);
        step("held_clear",  1,  1,   0,    32'hBAD0BAD0, 0,   0,    0, 0,   BUB,  2'b01, 1,  1,  32'hBAD0BAD0);
        step("refetch",     1,  1,   1,    32'h33333333, 0,   0,    0, 0,   ALL,  2'b00, 0,  1,  32'h33333333);
        step("load_use",    1,  1,   1,    32'h34343434, 0,   0,    0, 1,   BUB,  2'b01, 1,  0,  '0);
        step("br_over_lu",  1,  1,   1,    32'h35353535, 0,   0,    1, 1,   ALL,  2'b11, 0,  0,  '0);
        // Load-use bubble keeps a captured word
        step("cap2",        1,  1,   1,    32'h44444444, 1,   0,    0, 0,   NONE, 2'b00, 1,  1,  32'h44444444);
        step("lu_keep",     1,  1,   0,    32'h0BADF00D, 1,   1,    0, 1,   BUB,  2'b01, 1,  1,  32'h44444444);
        step("lu_consume",  1,  1,   0,    32'h0BADF00D, 0,   0,    0, 0,   ALL,  2'b00, 0,  1,  32'h44444444);
        step("after_cons",  1,  1,   0,    32'h0BADF00D, 0,   0,    0, 0,   BUB,  2'b01, 1,  0,  '0);
        // Branch discards a captured word
        step("cap3",        1,  1,   1,    32'h55555555, 1,   0,    0, 0,   NONE, 2'b00, 1,  1,  32'h55555555);
        step("br_discard",  1,  1,   0,    32'h0BADF00D, 1,   1,    1, 0,   ALL,  2'b11, 0,  0,  '0);
        step("discarded",   1,  1,   0,    32'h0BADF00D, 0,   0,    0, 0,   BUB,  2'b01, 1,  1,  32'h0BADF00D);
        // Branch during a D-freeze waits for the advance
        step("br_frozen",   1,  1,   1,    32'h60606060, 1,   0,    1, 0,   NONE, 2'b00, 1,  0,  '0);
        step("br_applied",  1,  1,   0,    32'h0,        1,   1,    1, 0,   ALL,  2'b11, 0,  0,  '0);
        // Both responses together: advance without capture
        step("both_resp",   1,  1,   1,    32'h66666666, 1,   1,    0, 0,   ALL,  2'b00, 0,  1,  32'h66666666);
        step("no_capture",  1,  1,   0,    32'h67676767, 0,   0,    0, 0,   BUB,  2'b01, 1,  1,  32'h67676767);
        // Both misses, then asynchronous reset mid-miss
        step("wait_id",     1,  1,   0,    32'h0,        1,   0,    0, 0,   NONE, 2'b00, 1,  0,  '0);
        step("rst_mid",     0,  1,   0,    32'h0,        1,   0,    0, 0,   NONE, 2'b00, 0,  0,  '0);
        step("post_rst",    1,  1,   1,    32'h77777777, 0,   0,    0, 0,   ALL,  2'b00, 0,  1,  32'h77777777);
        step("post_rst_im", 1,  1,   0,    32'h78787878, 0,   0,    0, 0,   BUB,  2'b01, 1,  1,  32'h78787878);
        repeat (2) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
